// File: rtl/s2p_cond_pkg.sv
//==============================================================================
// s2p_cond_pkg : shared FSM encodings, default comma and counter widths
// Rev 1.0 : initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package s2p_cond_pkg;

   localparam logic [7:0] S2P_COM_DEFAULT = 8'hBC;
   localparam int         BIT_CNT_W       = 3;
   localparam int         COM_CNT_W       = 3;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_LOCKING = 2'd1,
      ST_ACTIVE  = 2'd2
   } s2p_state_e;

   function automatic logic is_comma(input logic [7:0] b, input logic [7:0] com);
      return (b == com);
   endfunction

endpackage

`default_nettype wire

// File: rtl/s2p_cond_sipo.sv
//==============================================================================
// sipo_s2p_cond : 8-bit MSB-first shift register, enable, async active-low clear
// Rev 1.0 : initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sipo_s2p_cond (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       en_i,
   input  logic       bit_i,
   output logic [7:0] sr_o
);

   logic [7:0] sr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sr_q <= 8'h00;
      end else if (en_i) begin
         sr_q <= {sr_q[6:0], bit_i};
      end
   end

   assign sr_o = sr_q;

endmodule

`default_nettype wire

// File: rtl/s2p_cond.sv
//==============================================================================
// s2p_cond : 4-lane serial-to-parallel receiver with comma alignment and lock
// Rev 1.0 : initial release; optional comma stripping via S2P_COM_STRIP_EN
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module s2p_cond
   import s2p_cond_pkg::*;
#(
   parameter logic [7:0]  COM_SYMBOL = S2P_COM_DEFAULT,
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic       IN_CLK_s2p,
   input  logic       IN_RESET_s2p,
   input  logic [3:0] IN_LANE_s2p,
   input  logic       IN_ENB_s2p,
   output logic [7:0] OUT_LANE3_s2p,
   output logic [7:0] OUT_LANE2_s2p,
   output logic [7:0] OUT_LANE1_s2p,
   output logic [7:0] OUT_LANE0_s2p,
   output logic       OUT_VALID_s2p,
   output logic       OUT_ACTIVE_s2p
);

   localparam logic [COM_CNT_W-1:0] COM_LAST = COM_CNT_W'(LOCK_COUNT - 1);

   logic [7:0]           sr [4];
   s2p_state_e           state_q;
   logic [BIT_CNT_W-1:0] bit_cnt_q;
   logic [BIT_CNT_W-1:0] bit_cnt_d;
   logic [COM_CNT_W-1:0] com_cnt_q;
   logic [7:0]           lane_q [4];
   logic                 valid_q;
   logic                 active_q;
   logic                 com_hit;
   logic                 boundary;
   logic                 load_en;

   for (genvar n = 0; n < 4; n++) begin : g_lane
      sipo_s2p_cond u_sipo (
         .clk_i  (IN_CLK_s2p),
         .rst_ni (IN_RESET_s2p),
         .en_i   (IN_ENB_s2p),
         .bit_i  (IN_LANE_s2p[n]),
         .sr_o   (sr[n])
      );
   end

   assign com_hit   = is_comma(sr[0], COM_SYMBOL);
   assign boundary  = (bit_cnt_q == '0);
   assign bit_cnt_d = bit_cnt_q + 3'd1;

`ifdef S2P_COM_STRIP_EN
   assign load_en = !com_hit;
`else
   assign load_en = 1'b1;
`endif

   always_ff @(posedge IN_CLK_s2p or negedge IN_RESET_s2p) begin
      if (!IN_RESET_s2p) begin
         state_q   <= ST_SEARCH;
         bit_cnt_q <= '0;
         com_cnt_q <= '0;
         valid_q   <= 1'b0;
         active_q  <= 1'b0;
         for (int n = 0; n < 4; n++) lane_q[n] <= 8'h00;
      end else begin
         valid_q <= 1'b0;
         // Enable low wins over everything, including a pending boundary load.
         if (!IN_ENB_s2p) begin
            state_q   <= ST_SEARCH;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            active_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_SEARCH: begin
                  if (com_hit) begin
                     state_q   <= ST_LOCKING;
                     bit_cnt_q <= 3'd1;
                     com_cnt_q <= 3'd1;
                  end
               end
               ST_LOCKING: begin
                  bit_cnt_q <= bit_cnt_d;
                  if (boundary) begin
                     if (!com_hit) begin
                        state_q   <= ST_SEARCH;
                        bit_cnt_q <= '0;
                        com_cnt_q <= '0;
                     end else if (com_cnt_q == COM_LAST) begin
                        state_q  <= ST_ACTIVE;
                        active_q <= 1'b1;
                     end else begin
                        com_cnt_q <= com_cnt_q + 3'd1;
                     end
                  end
               end
               ST_ACTIVE: begin
                  bit_cnt_q <= bit_cnt_d;
                  if (boundary && load_en) begin
                     for (int n = 0; n < 4; n++) lane_q[n] <= sr[n];
                     valid_q <= 1'b1;
                  end
               end
               default: begin
                  state_q   <= ST_SEARCH;
                  bit_cnt_q <= '0;
                  com_cnt_q <= '0;
                  active_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign OUT_LANE3_s2p  = lane_q[3];
   assign OUT_LANE2_s2p  = lane_q[2];
   assign OUT_LANE1_s2p  = lane_q[1];
   assign OUT_LANE0_s2p  = lane_q[0];
   assign OUT_VALID_s2p  = valid_q;
   assign OUT_ACTIVE_s2p = active_q;

endmodule

`default_nettype wire

// File: tb/tb_s2p_cond.sv
//==============================================================================
// tb_s2p_cond : scoreboard bench for s2p_cond (directed serial streams)
// Rev 1.0 : initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_s2p_cond;

   localparam logic [7:0] COM = 8'hBC;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enb = 1'b0;
   logic [3:0] lane = 4'h0;
   logic [7:0] l3, l2, l1, l0;
   logic       valid, active;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_v = -1;
   logic [31:0] exp_q[$];

   s2p_cond #(.COM_SYMBOL(8'hBC), .LOCK_COUNT(4)) dut (
      .IN_CLK_s2p     (clk),
      .IN_RESET_s2p   (rst_n),
      .IN_LANE_s2p    (lane),
      .IN_ENB_s2p     (enb),
      .OUT_LANE3_s2p  (l3),
      .OUT_LANE2_s2p  (l2),
      .OUT_LANE1_s2p  (l1),
      .OUT_LANE0_s2p  (l0),
      .OUT_VALID_s2p  (valid),
      .OUT_ACTIVE_s2p (active)
   );

   always #250 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every valid pulse pops one expected word.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL unexpected_valid: got %h expected no pulse", {l3, l2, l1, l0});
         end else begin
            check("word", {l3, l2, l1, l0}, exp_q.pop_front());
         end
         if (last_v >= 0) check("valid_gap_ge8", 32'((cyc - last_v) >= 8), 32'd1);
         last_v = cyc;
      end
   end

   task automatic send_word(input logic [7:0] b3, input logic [7:0] b2,
                            input logic [7:0] b1, input logic [7:0] b0);
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk);
         lane = {b3[i], b2[i], b1[i], b0[i]};
      end
   endtask

   task automatic send_data(input logic [7:0] b3, input logic [7:0] b2,
                            input logic [7:0] b1, input logic [7:0] b0);
      exp_q.push_back({b3, b2, b1, b0});
      send_word(b3, b2, b1, b0);
   endtask

   task automatic send_com(input int n);
      for (int k = 0; k < n; k++) send_word(8'h00, 8'h00, 8'h00, COM);
   endtask

   task automatic send_bits0(input logic [7:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk);
         lane = {3'b000, v[i]};
      end
   endtask

   // Run right after the last comma bit has been driven.
   task automatic check_lock(input string name);
      @(negedge clk);
      check({name, "_pre"}, {31'd0, active}, 32'd0);
      @(negedge clk);
      check({name, "_rise"}, {31'd0, active}, 32'd1);
   endtask

   task automatic idle_then_resync();
      repeat (2) begin @(negedge clk); lane = 4'h0; end
      @(negedge clk); enb = 1'b0;
      @(negedge clk); enb = 1'b0;
      @(negedge clk); enb = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_lanes", {l3, l2, l1, l0}, 32'h0);
      check("reset_flags", {30'd0, valid, active}, 32'd0);
      rst_n = 1'b1;
      enb   = 1'b1;

      // Aligned lock, then two words; first valid 8 cycles after ACTIVE rises.
      send_com(4);
      fork
         begin
            send_data(8'h11, 8'h22, 8'h33, 8'hA5);
            send_data(8'h44, 8'h55, 8'h66, 8'h5A);
         end
         begin
            check_lock("lock_a");
            repeat (8) @(negedge clk);
            check("first_valid", {31'd0, valid}, 32'd1);
         end
      join

      // ENB low for one cycle three bits into a byte.
      for (int i = 7; i >= 0; i--) begin
         @(negedge clk);
         if (i == 3) begin
            check("enb_drop_active", {31'd0, active}, 32'd0);
            check("enb_drop_hold", {l3, l2, l1, l0}, 32'h4455665A);
         end
         lane = 4'h0;
         enb  = (i != 4);
      end
      send_word(8'h00, 8'h00, 8'h00, 8'h00);
      send_word(8'h00, 8'h00, 8'h00, 8'h00);
      send_com(4);
      fork
         send_data(8'h77, 8'h88, 8'h99, 8'hC3);
         check_lock("relock_enb");
      join

      // Comma inside ACTIVE followed by data.
`ifndef S2P_COM_STRIP_EN
      exp_q.push_back({8'h01, 8'h02, 8'h03, COM});
`endif
      send_word(8'h01, 8'h02, 8'h03, COM);
      send_data(8'h0F, 8'hF0, 8'h3C, 8'hA5);
      idle_then_resync();

      // Three garbage bits then lock at the shifted offset.
      send_bits0(8'b0000_0101, 3);
      send_com(4);
      fork
         send_data(8'h00, 8'h00, 8'h00, 8'h7E);
         check_lock("lock_offset");
      join
      idle_then_resync();

      // BC, BC, 00 must fall back to SEARCH without ever asserting ACTIVE.
      fork
         begin
            send_com(2);
            send_word(8'h00, 8'h00, 8'h00, 8'h00);
         end
         begin
            logic seen;
            seen = 1'b0;
            repeat (26) begin
               @(negedge clk);
               if (active !== 1'b0) seen = 1'b1;
            end
            check("no_lock_bcbc00", {31'd0, seen}, 32'd0);
         end
      join
      send_com(4);
      fork
         send_data(8'hA1, 8'hB2, 8'hC3, 8'hD4);
         check_lock("relock_bad");
      join

      // Asynchronous reset mid-byte while ACTIVE.
      for (int i = 7; i >= 4; i--) begin
         @(negedge clk);
         lane = 4'hF;
      end
      check("pre_reset_active", {31'd0, active}, 32'd1);
      #10 rst_n = 1'b0;
      #1;
      check("async_rst_lanes", {l3, l2, l1, l0}, 32'h0);
      check("async_rst_flags", {30'd0, valid, active}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send_word(8'h00, 8'h00, 8'h00, 8'h00);
      send_word(8'h00, 8'h00, 8'h00, 8'h00);
      check("post_rst_active", {31'd0, active}, 32'd0);

      repeat (4) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
